ex_mem_stage_controller: RTL and testbench

- EX/MEM pipeline register and cache-switch sequencer, directly upstream of memory_access_unit.
- Captures EX-stage results and drives the MEM-stage control/data inputs; holds them while the data cache reports busywait.
- Turns a cache-switch instruction into a one-cycle cache-select write, then a settle window during which the pipeline is stalled and bubbles are issued.

---
 rtl/ex_mem_stage_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_ex_mem_stage_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_controller.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_controller
//
// Purpose:
//   This block is the EX/MEM pipeline register and the cache-switch sequencer.
//   It sits directly upstream of memory_access_unit.
//   - It captures the EX-stage results and drives the MEM-stage control and
//     data inputs.
//   - It holds those MEM-side registers while the data cache reports busywait.
//   - A cache-switch instruction becomes a one-cycle cache-select write pulse.
//     A settle window of SETTLE_CYCLES stalled cycles follows. A bubble sits
//     in the MEM slot for the whole sequence.
//
// Parameters:
//   SETTLE_CYCLES  stall cycles after the cache-select write pulse (0 allowed)
//   MAX_CACHE_ID   highest valid cache index (<= 7)
//
// Optional feature (macro SWITCH_COUNTER_EN):
//   Adds switch_count[15:0]. It counts SWITCH cycles and saturates at 0xFFFF.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   ex_valid .. ex_cache_id       EX-stage instruction fields
//   flush                         kill the EX instruction at capture
//   data_memory_busywait          MEM stage busy; hold the MEM registers
//   mem_read_signal, mem_write_signal, mux4_out_result, data2, func3,
//   mem_rd, mem_reg_write         registered MEM-stage outputs
//   func3_cache_select_reg_value  latched cache index
//   write_cache_select_reg        cache-select write pulse (SWITCH cycle)
//   bad_switch                    one-cycle pulse on an out-of-range cache id
//   stall_out                     combinational; upstream holds when 1
// ---------------------------------------------------------------------------
module ex_mem_stage_controller #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_CACHE_ID  = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_data2,
    input  logic [2:0]  ex_func3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_cache_switch,
    input  logic [2:0]  ex_cache_id,
    input  logic        flush,
    input  logic        data_memory_busywait,
    output logic        mem_read_signal,
    output logic        mem_write_signal,
    output logic [31:0] mux4_out_result,
    output logic [31:0] data2,
    output logic [2:0]  func3,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic [2:0]  func3_cache_select_reg_value,
    output logic        write_cache_select_reg,
    output logic        bad_switch,
`ifdef SWITCH_COUNTER_EN
    output logic [15:0] switch_count,
`endif
    output logic        stall_out
);

    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;
    localparam logic [2:0]    MAX_ID      = 3'(MAX_CACHE_ID);
    localparam bit            HAS_SETTLE  = (SETTLE_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;

    logic            hold_s;
    logic            take_s;
    logic            cap_op_s;
    logic            good_sw_s;
    logic            bad_sw_s;

    logic            mem_read_r, mem_write_r, mem_reg_write_r;
    logic [31:0]     addr_r, data2_r;
    logic [2:0]      func3_r;
    logic [4:0]      rd_r;
    logic [2:0]      cache_sel_r;
    logic            wsel_r;
    logic            bad_r;

    // Pipeline hold/take qualifiers and the classification of a taken switch.
    always_comb begin
        hold_s    = (state_r == ST_RUN) && data_memory_busywait;
        take_s    = (state_r == ST_RUN) && !data_memory_busywait && ex_valid && !flush;
        cap_op_s  = take_s && !ex_cache_switch;
        good_sw_s = take_s && ex_cache_switch && (ex_cache_id <= MAX_ID);
        bad_sw_s  = take_s && ex_cache_switch && (ex_cache_id > MAX_ID);
    end

    // Stall is combinational so upstream freezes in the same cycle.
    // The cycle that consumes a switch is not stalled.
    always_comb begin
        stall_out = hold_s || (state_r != ST_RUN);
    end

    // Next-state and settle counter logic for the switch sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (good_sw_s) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SWITCH: begin
                if (HAS_SETTLE) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = SETTLE_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Sequencer state register. Reset abandons any switch or settle in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // MEM-side pipeline registers.
    // They hold under busywait, capture a normal op, and otherwise load a
    // zeroed bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_reg_write_r <= 1'b0;
            addr_r          <= 32'd0;
            data2_r         <= 32'd0;
            func3_r         <= 3'd0;
            rd_r            <= 5'd0;
        end else if (!hold_s) begin
            if (cap_op_s) begin
                mem_read_r      <= ex_mem_read;
                mem_write_r     <= ex_mem_write;
                mem_reg_write_r <= ex_reg_write;
                addr_r          <= ex_alu_result;
                data2_r         <= ex_data2;
                func3_r         <= ex_func3;
                rd_r            <= ex_rd;
            end else begin
                mem_read_r      <= 1'b0;
                mem_write_r     <= 1'b0;
                mem_reg_write_r <= 1'b0;
                addr_r          <= 32'd0;
                data2_r         <= 32'd0;
                func3_r         <= 3'd0;
                rd_r            <= 5'd0;
            end
        end
    end

    // Cache-select id latch, write pulse and bad-id pulse.
    // The write pulse is high exactly in the SWITCH cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cache_sel_r <= 3'd0;
            wsel_r      <= 1'b0;
            bad_r       <= 1'b0;
        end else begin
            if (good_sw_s) begin
                cache_sel_r <= ex_cache_id;
            end
            wsel_r <= good_sw_s;
            bad_r  <= bad_sw_s;
        end
    end

`ifdef SWITCH_COUNTER_EN
    logic [15:0] sw_cnt_r;

    // Saturating count of SWITCH cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_cnt_r <= 16'd0;
        end else if ((state_r == ST_SWITCH) && (sw_cnt_r != 16'hFFFF)) begin
            sw_cnt_r <= sw_cnt_r + 16'd1;
        end
    end

    assign switch_count = sw_cnt_r;
`endif

    assign mem_read_signal              = mem_read_r;
    assign mem_write_signal             = mem_write_r;
    assign mem_reg_write                = mem_reg_write_r;
    assign mux4_out_result              = addr_r;
    assign data2                        = data2_r;
    assign func3                        = func3_r;
    assign mem_rd                       = rd_r;
    assign func3_cache_select_reg_value = cache_sel_r;
    assign write_cache_select_reg       = wsel_r;
    assign bad_switch                   = bad_r;

endmodule

// File: tb/tb_ex_mem_stage_controller.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_controller
//
// Directed bench for ex_mem_stage_controller with SETTLE_CYCLES=4 and
// MAX_CACHE_ID=3.
// - A cycle-level reference model predicts every registered output and
//   stall_out.
// - A compare process checks the DUT against the model on each falling edge.
// - Hand-computed literal checks pin the model to the intended behaviour.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_controller;

    localparam int SETTLE = 4;
    localparam int MAXID  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [31:0] ex_alu_result, ex_data2;
    logic [2:0]  ex_func3;
    logic [4:0]  ex_rd;
    logic        ex_cache_switch;
    logic [2:0]  ex_cache_id;
    logic        flush, data_memory_busywait;
    logic        mem_read_signal, mem_write_signal, mem_reg_write;
    logic [31:0] mux4_out_result, data2;
    logic [2:0]  func3, mem_rd_hi;
    logic [4:0]  mem_rd;
    logic [2:0]  func3_cache_select_reg_value;
    logic        write_cache_select_reg, bad_switch, stall_out;

    int n_chk  = 0;
    int n_pass = 0;

    ex_mem_stage_controller #(.SETTLE_CYCLES(SETTLE), .MAX_CACHE_ID(MAXID)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_alu_result(ex_alu_result), .ex_data2(ex_data2),
        .ex_func3(ex_func3), .ex_rd(ex_rd), .ex_cache_switch(ex_cache_switch),
        .ex_cache_id(ex_cache_id), .flush(flush), .data_memory_busywait(data_memory_busywait),
        .mem_read_signal(mem_read_signal), .mem_write_signal(mem_write_signal),
        .mux4_out_result(mux4_out_result), .data2(data2), .func3(func3), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write),
        .func3_cache_select_reg_value(func3_cache_select_reg_value),
        .write_cache_select_reg(write_cache_select_reg), .bad_switch(bad_switch),
        .stall_out(stall_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model state.
    // sw_left is the number of stalled cycles still owed to a switch sequence
    // (write pulse cycle plus settle window).
    logic        m_rd_sig, m_wr_sig, m_regw, m_wsel, m_bad;
    logic [31:0] m_addr, m_data2;
    logic [2:0]  m_func3, m_csel;
    logic [4:0]  m_rdst;
    int          sw_left;
    bit          m_hold, m_take;

    task automatic m_bubble();
        m_rd_sig = 1'b0; m_wr_sig = 1'b0; m_regw = 1'b0;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_bubble();
            m_addr = 32'd0; m_data2 = 32'd0; m_func3 = 3'd0; m_rdst = 5'd0;
            m_csel = 3'd0; m_wsel = 1'b0; m_bad = 1'b0; sw_left = 0;
        end else begin
            m_hold = (sw_left == 0) && data_memory_busywait;
            m_take = (sw_left == 0) && !data_memory_busywait && ex_valid && !flush;
            m_wsel = 1'b0;
            m_bad  = 1'b0;
            if (sw_left > 0) begin
                m_bubble();
                sw_left = sw_left - 1;
            end else if (m_hold) begin
                // MEM slot frozen
            end else if (m_take && ex_cache_switch) begin
                m_bubble();
                if (int'(ex_cache_id) <= MAXID) begin
                    m_wsel  = 1'b1;
                    m_csel  = ex_cache_id;
                    sw_left = 1 + SETTLE;
                end else begin
                    m_bad = 1'b1;
                end
            end else if (m_take) begin
                m_rd_sig = ex_mem_read; m_wr_sig = ex_mem_write; m_regw = ex_reg_write;
                m_addr = ex_alu_result; m_data2 = ex_data2; m_func3 = ex_func3; m_rdst = ex_rd;
            end else begin
                m_bubble();
            end
        end
    end

    // Per-cycle comparison against the model.
    // Data fields are only meaningful when the MEM slot holds an operation.
    always @(negedge clock) begin
        if (reset) begin
            chk("mem_read_signal", {31'd0, mem_read_signal}, {31'd0, m_rd_sig});
            chk("mem_write_signal", {31'd0, mem_write_signal}, {31'd0, m_wr_sig});
            chk("mem_reg_write", {31'd0, mem_reg_write}, {31'd0, m_regw});
            chk("cache_sel_value", {29'd0, func3_cache_select_reg_value}, {29'd0, m_csel});
            chk("write_cache_sel", {31'd0, write_cache_select_reg}, {31'd0, m_wsel});
            chk("bad_switch", {31'd0, bad_switch}, {31'd0, m_bad});
            chk("stall_out", {31'd0, stall_out},
                {31'd0, (sw_left > 0) || data_memory_busywait});
            if (m_rd_sig || m_wr_sig || m_regw) begin
                chk("mux4_out_result", mux4_out_result, m_addr);
                chk("data2", data2, m_data2);
                chk("func3", {29'd0, func3}, {29'd0, m_func3});
                chk("mem_rd", {27'd0, mem_rd}, {27'd0, m_rdst});
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        ex_alu_result = 32'd0; ex_data2 = 32'd0; ex_func3 = 3'd0; ex_rd = 5'd0;
        ex_cache_switch = 1'b0; ex_cache_id = 3'd0; flush = 1'b0;
    endtask

    task automatic ex_load(input logic [31:0] a, input logic [4:0] rd);
        ex_clear();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        ex_alu_result = a; ex_func3 = 3'b010; ex_rd = rd;
    endtask

    task automatic ex_switch(input logic [2:0] id);
        ex_clear();
        ex_valid = 1'b1; ex_cache_switch = 1'b1; ex_cache_id = id;
    endtask

    int stall_cnt;
    int wsel_cnt;

    initial begin
        reset = 1'b0;
        data_memory_busywait = 1'b0;
        ex_clear();
        mem_rd_hi = 3'd0;
        cyc(); cyc();
        chk("rst_mem_read", {31'd0, mem_read_signal}, 32'd0);
        chk("rst_addr", mux4_out_result, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        reset = 1'b1;
        cyc();

        // Load capture
        ex_load(32'h100, 5'd5);
        cyc();
        chk("load_read", {31'd0, mem_read_signal}, 32'd1);
        chk("load_addr", mux4_out_result, 32'h100);
        chk("load_rd", {27'd0, mem_rd}, 32'd5);
        chk("load_stall", {31'd0, stall_out}, 32'd0);

        // Store, then 3 busywait cycles with the next load waiting in EX
        ex_clear();
        ex_valid = 1'b1; ex_mem_write = 1'b1; ex_alu_result = 32'h200;
        ex_data2 = 32'hDEADBEEF; ex_func3 = 3'b010;
        cyc();
        ex_load(32'h300, 5'd7);
        data_memory_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            chk("busy_stall", {31'd0, stall_out}, 32'd1);
            cyc();
            chk("busy_hold_addr", mux4_out_result, 32'h200);
            chk("busy_hold_wr", {31'd0, mem_write_signal}, 32'd1);
        end
        flush = 1'b0;
        data_memory_busywait = 1'b0;
        cyc();
        chk("post_busy_addr", mux4_out_result, 32'h300);

        // Flush a valid load
        ex_load(32'h340, 5'd9);
        flush = 1'b1;
        cyc();
        chk("flush_bubble", {31'd0, mem_read_signal}, 32'd0);

        // Good switch to cache 3
        ex_switch(3'd3);
        #1;
        chk("switch_take_stall", {31'd0, stall_out}, 32'd0);
        cyc();
        chk("switch_pulse", {31'd0, write_cache_select_reg}, 32'd1);
        chk("switch_id", {29'd0, func3_cache_select_reg_value}, 32'd3);
        ex_load(32'h400, 5'd11);
        stall_cnt = 0;
        wsel_cnt  = 0;
        for (int i = 0; i < 20 && stall_out; i++) begin
            stall_cnt++;
            if (write_cache_select_reg) wsel_cnt++;
            cyc();
        end
        chk("switch_stall_len", stall_cnt, 32'd5);
        chk("switch_pulse_cnt", wsel_cnt, 32'd1);
        cyc();
        chk("after_switch_load", mux4_out_result, 32'h400);
        chk("id_held", {29'd0, func3_cache_select_reg_value}, 32'd3);

        // Out-of-range switch
        ex_switch(3'd5);
        cyc();
        chk("bad_pulse", {31'd0, bad_switch}, 32'd1);
        chk("bad_no_write", {31'd0, write_cache_select_reg}, 32'd0);
        chk("bad_no_stall", {31'd0, stall_out}, 32'd0);
        ex_clear();
        cyc();
        chk("bad_pulse_end", {31'd0, bad_switch}, 32'd0);

        // Reset during settle
        ex_switch(3'd2);
        cyc();
        ex_clear();
        cyc(); cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_settle_csel", {29'd0, func3_cache_select_reg_value}, 32'd0);
        chk("rst_settle_wsel", {31'd0, write_cache_select_reg}, 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_release_stall", {31'd0, stall_out}, 32'd0);
        cyc(); cyc();
        chk("rst_release_csel", {29'd0, func3_cache_select_reg_value}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
